// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed N-digit seven-segment scanner.
//
// A refresh divider advances the scan one digit slot every REFRESH_DIV
// clocks. Digit values come from a display buffer that only changes on the
// frame boundary, so a frame is never torn. A load outside the boundary is
// parked in a pending buffer (last load wins) and promoted on the next
// boundary. A load on the boundary itself goes straight to the display
// buffer.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   data       hex nibbles, nibble i drives digit i (digit 0 rightmost)
//   load       capture data (pending, or display on a boundary cycle)
//   dp_en      per-digit decimal point, sampled live
//   digit_en   per-digit enable, sampled live
//   blank_lz   enable leading-zero blanking
//   SEG        active-low segments, SEG[7]=dp, SEG[6:0]=g..a (registered)
//   AN         active-low anode selects (registered)
//   scan_idx   digit slot currently being scanned
//   frame_done high during the boundary cycle (last slot, tick)
module seg_scan_driver #(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 12500,
  parameter int CNT_W       = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_en,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  blank_lz,
  output logic [7:0]            SEG,
  output logic [DIGITS-1:0]     AN,
  output logic [3:0]            scan_idx,
  output logic                  frame_done
);

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [3:0]       SCAN_LAST = 4'(DIGITS - 1);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  logic [CNT_W-1:0]    div_q, div_d;
  logic [3:0]          scan_q, scan_d;
  logic                fd_q, fd_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [4*DIGITS-1:0] pend_q, pend_d;
  logic                pv_q, pv_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                tick, wrap, boundary;
  logic [DIGITS-1:0]   zero_from;  // nibbles DIGITS-1 down to i all zero

  // Divider and scan position.
  always_comb begin
    tick     = (div_q == DIV_LAST);
    wrap     = (scan_q == SCAN_LAST);
    boundary = tick && wrap;
    div_d    = tick ? '0 : div_q + 1'b1;
    scan_d   = scan_q;
    if (tick) scan_d = wrap ? 4'd0 : scan_q + 4'd1;
    // Look one cycle ahead so the registered pulse lands on the boundary
    // cycle itself rather than the cycle after it.
    fd_d     = (div_d == DIV_LAST) && (scan_d == SCAN_LAST);
  end

  // Double buffer: display only moves on the boundary.
  always_comb begin
    disp_d = disp_q;
    pend_d = pend_q;
    pv_d   = pv_q;
    if (boundary) begin
      if (load)      disp_d = data;
      else if (pv_q) disp_d = pend_q;
      pv_d = 1'b0;
    end else if (load) begin
      pend_d = data;
      pv_d   = 1'b1;
    end
  end

  // Leading-zero map, walked from the most significant digit down.
  always_comb begin
    logic z;
    z         = 1'b1;
    zero_from = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      z            = z & (disp_q[4*i +: 4] == 4'h0);
      zero_from[i] = z;
    end
  end

  // Output decode for the slot being scanned this cycle.
  always_comb begin
    an_d  = '1;
    seg_d = 8'hFF;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_q == 4'(i) && digit_en[i] &&
          !(blank_lz && (i > 0) && zero_from[i])) begin
        an_d[i] = 1'b0;
        seg_d   = {~dp_en[i], hex7(disp_q[4*i +: 4])};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= '0;
      scan_q <= '0;
      fd_q   <= 1'b0;
      disp_q <= '0;
      pend_q <= '0;
      pv_q   <= 1'b0;
      seg_q  <= 8'hFF;
      an_q   <= '1;
    end else begin
      div_q  <= div_d;
      scan_q <= scan_d;
      fd_q   <= fd_d;
      disp_q <= disp_d;
      pend_q <= pend_d;
      pv_q   <= pv_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end
  end

  assign SEG        = seg_q;
  assign AN         = an_q;
  assign scan_idx   = scan_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (DIGITS=4, REFRESH_DIV=4). A reference model
// derived from elapsed cycles since reset predicts every output each cycle;
// directed vectors and sequences cover the display cases and corners.
module tb_seg_scan_driver;
  localparam int D  = 4;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = '0;
  logic        load = 1'b0;
  logic [3:0]  dp_en = '0;
  logic [3:0]  digit_en = 4'hF;
  logic        blank_lz = 1'b0;
  logic [7:0]  SEG;
  logic [3:0]  AN;
  logic [3:0]  scan_idx;
  logic        frame_done;

  seg_scan_driver #(.DIGITS(D), .REFRESH_DIV(RD), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .data(data), .load(load), .dp_en(dp_en),
    .digit_en(digit_en), .blank_lz(blank_lz), .SEG(SEG), .AN(AN),
    .scan_idx(scan_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [6:0] hexc [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state: t counts clocks since reset release.
  int          t;
  logic [15:0] m_disp, m_pend;
  logic        m_pv;
  logic [7:0]  m_seg;
  logic [3:0]  m_an;
  logic [3:0]  m_scan;
  logic        m_fd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    t = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0;
    m_seg = 8'hFF; m_an = 4'hF; m_scan = '0; m_fd = 1'b0;
  endtask

  task automatic model_clk();
    int  sc, dv;
    bit  bnd, blank;
    if (!rst) begin
      model_reset();
      return;
    end
    sc  = (t / RD) % D;
    dv  = t % RD;
    bnd = (dv == RD - 1) && (sc == D - 1);
    blank = blank_lz && (sc > 0) && ((m_disp >> (4 * sc)) == 16'h0);
    m_an = 4'hF; m_seg = 8'hFF;
    if (digit_en[sc] && !blank) begin
      m_an[sc] = 1'b0;
      m_seg = {~dp_en[sc], hexc[m_disp[4*sc +: 4]]};
    end
    if (bnd) begin
      if (load) m_disp = data;
      else if (m_pv) m_disp = m_pend;
      m_pv = 1'b0;
    end else if (load) begin
      m_pend = data;
      m_pv = 1'b1;
    end
    t++;
    m_scan = 4'((t / RD) % D);
    m_fd = ((t % RD) == RD - 1) && (((t / RD) % D) == D - 1);
  endtask

  task automatic step();
    @(posedge clk);
    model_clk();
    #1;
    chk("m_seg", 32'(SEG), 32'(m_seg));
    chk("m_an", 32'(AN), 32'(m_an));
    chk("m_scan", 32'(scan_idx), 32'(m_scan));
    chk("m_fd", 32'(frame_done), 32'(m_fd));
  endtask

  task automatic wait_fd();
    int n = 0;
    while (!frame_done && n < 64) begin step(); n++; end
    chk("fd_timeout", 32'(frame_done), 32'd1);
  endtask

  task automatic wait_scan(input int k);
    int n = 0;
    while (scan_idx != 4'(k) && n < 64) begin step(); n++; end
    chk("scan_timeout", 32'(scan_idx), 32'(k));
  endtask

  // Load, then run past the next boundary so the value is on display.
  task automatic load_commit(input logic [15:0] d);
    data = d; load = 1'b1;
    step();
    load = 1'b0;
    wait_fd();
    step();
  endtask

  task automatic show(input string nm, input int slot, input logic [3:0] an, input logic [7:0] seg);
    wait_scan(slot);
    step();
    chk({nm, "_an"}, 32'(AN), 32'(an));
    chk({nm, "_seg"}, 32'(SEG), 32'(seg));
  endtask

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic        blz;
    int          slot;
    logic [3:0]  an;
    logic [7:0]  seg;
  } vec_t;

  vec_t vecs[18];

  initial begin
    int fdcnt;
    vecs[0]  = '{16'h12A0, 4'h0, 4'hF, 1'b0, 0, 4'hE, 8'hC0};
    vecs[1]  = '{16'h1234, 4'h0, 4'hF, 1'b0, 0, 4'hE, 8'h99};
    vecs[2]  = '{16'h1234, 4'h0, 4'hF, 1'b0, 1, 4'hD, 8'hB0};
    vecs[3]  = '{16'h1234, 4'h0, 4'hF, 1'b0, 2, 4'hB, 8'hA4};
    vecs[4]  = '{16'h1234, 4'h0, 4'hF, 1'b0, 3, 4'h7, 8'hF9};
    vecs[5]  = '{16'h0050, 4'h0, 4'hF, 1'b1, 3, 4'hF, 8'hFF};
    vecs[6]  = '{16'h0050, 4'h0, 4'hF, 1'b1, 2, 4'hF, 8'hFF};
    vecs[7]  = '{16'h0050, 4'h0, 4'hF, 1'b1, 1, 4'hD, 8'h92};
    vecs[8]  = '{16'h0050, 4'h0, 4'hF, 1'b1, 0, 4'hE, 8'hC0};
    vecs[9]  = '{16'h0000, 4'h0, 4'hF, 1'b1, 0, 4'hE, 8'hC0};
    vecs[10] = '{16'h0000, 4'h0, 4'hF, 1'b1, 1, 4'hF, 8'hFF};
    vecs[11] = '{16'h0000, 4'h0, 4'hF, 1'b1, 3, 4'hF, 8'hFF};
    vecs[12] = '{16'h8888, 4'h2, 4'hB, 1'b0, 1, 4'hD, 8'h00};
    vecs[13] = '{16'h8888, 4'h2, 4'hB, 1'b0, 2, 4'hF, 8'hFF};
    vecs[14] = '{16'h8888, 4'h2, 4'hB, 1'b0, 0, 4'hE, 8'h80};
    vecs[15] = '{16'h8888, 4'h2, 4'hB, 1'b0, 3, 4'h7, 8'h80};
    vecs[16] = '{16'h0050, 4'h0, 4'hF, 1'b0, 3, 4'h7, 8'hC0};
    vecs[17] = '{16'hFEDC, 4'hF, 4'hF, 1'b1, 3, 4'h7, 8'h0E};

    // Reset hold.
    model_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_seg", 32'(SEG), 32'hFF);
    chk("rst_an", 32'(AN), 32'hF);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_scan", 32'(scan_idx), 32'd0);
    step(); step();

    // Release with a load pending; it commits at the first boundary.
    data = 16'h12A0; load = 1'b1;
    #2 rst = 1'b1;
    step();
    load = 1'b0;
    wait_fd();
    step();
    step();
    chk("first_an", 32'(AN), 32'hE);
    chk("first_seg", 32'(SEG), 32'hC0);

    // Directed vectors.
    for (int k = 0; k < 18; k++) begin
      dp_en = vecs[k].dp; digit_en = vecs[k].en; blank_lz = vecs[k].blz;
      load_commit(vecs[k].data);
      show($sformatf("vec%0d", k), vecs[k].slot, vecs[k].an, vecs[k].seg);
    end

    // Scan order over a full frame.
    dp_en = 4'h0; digit_en = 4'hF; blank_lz = 1'b0;
    load_commit(16'h1234);
    wait_fd();
    step();
    fdcnt = 0;
    for (int j = 0; j < 16; j++) begin
      step();
      chk("order_an", 32'(AN), 32'(~(4'b0001 << (j / 4)) & 4'hF));
      if (frame_done) begin
        fdcnt++;
        chk("fd_slot", 32'(scan_idx), 32'd3);
      end
    end
    chk("fd_count", 32'(fdcnt), 32'd1);

    // Tear-free: load during slot 1 must not show until next frame.
    load_commit(16'h0000);
    wait_scan(1);
    data = 16'h1234; load = 1'b1;
    step();
    load = 1'b0; data = 16'hFFFF;
    show("tear2", 2, 4'hB, 8'hC0);
    show("tear3", 3, 4'h7, 8'hC0);
    show("new0", 0, 4'hE, 8'h99);
    show("new3", 3, 4'h7, 8'hF9);

    // Boundary load wins over an older pending value, same frame.
    wait_scan(1);
    data = 16'h5555; load = 1'b1;
    step();
    load = 1'b0;
    wait_fd();
    data = 16'hABCD; load = 1'b1;
    step();
    load = 1'b0;
    step();
    chk("bnd_an", 32'(AN), 32'hE);
    chk("bnd_seg", 32'(SEG), 32'hA1);
    show("bnd3", 3, 4'h7, 8'h88);

    // Async reset mid-scan, off the clock edge.
    wait_scan(2);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("arst_seg", 32'(SEG), 32'hFF);
    chk("arst_an", 32'(AN), 32'hF);
    chk("arst_scan", 32'(scan_idx), 32'd0);
    chk("arst_fd", 32'(frame_done), 32'd0);
    step(); step();
    #2 rst = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      step();
      chk("slot0_len", 32'(scan_idx), (j < 4) ? 32'd0 : 32'd1);
    end

    // Randomized run against the model.
    for (int c = 0; c < 800; c++) begin
      logic [15:0] d;
      d = 16'($urandom);
      for (int n = 0; n < 4; n++) if ($urandom_range(0, 1) == 0) d[4*n +: 4] = 4'h0;
      data = d;
      load = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) dp_en = 4'($urandom);
      if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom);
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      step();
    end
    load = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
